wb_stage: RTL

// MEM/WB pipeline register plus writeback logic; the writing end of the register-file interface.

---
 rtl/wb_stage_if.sv | 32 +++
 rtl/wb_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle: MEM results and pipeline control in, register-file write port and
// retire/trap status out. master drives the MEM side, slave is the writeback stage.
interface wb_stage_if;
   logic        mem_valid;
   logic        mem_regWr;
   logic [4:0]  mem_writeimport;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_data;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_ld_type;
   logic [31:0] mem_pc;
   logic        stall;
   logic        flush;
   logic [4:0]  writeimport;
   logic [31:0] Writedata;
   logic        regWr;
   logic        wb_excp;
   logic [31:0] wb_badaddr;
   logic [31:0] wb_instret;

   modport master (
      output mem_valid, mem_regWr, mem_writeimport, mem_alu_result, mem_load_data,
             mem_wb_sel, mem_ld_type, mem_pc, stall, flush,
      input  writeimport, Writedata, regWr, wb_excp, wb_badaddr, wb_instret
   );

   modport slave (
      input  mem_valid, mem_regWr, mem_writeimport, mem_alu_result, mem_load_data,
             mem_wb_sel, mem_ld_type, mem_pc, stall, flush,
      output writeimport, Writedata, regWr, wb_excp, wb_badaddr, wb_instret
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback: load extraction, data select, one-shot
// register-file write under stall, misaligned-load trap and retired-instruction counter.
module wb_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] LINK_OFS = 32'd8
) (
   input logic        clk,
   input logic        rst,
   wb_stage_if.slave  wb
);

   // Handshake: mem_valid qualifies the MEM fields at each posedge; there is no ready,
   // the upstream holds via stall; wb_fired marks an instruction already written/retired.
   logic        valid_q, valid_d;
   logic        fired_q, fired_d;
   logic        load_en;
   logic        regwr_q;
   logic [4:0]  waddr_q;
   logic [31:0] alu_q;
   logic [31:0] ld_data_q;
   logic [1:0]  sel_q;
   logic [2:0]  ld_type_q;
   logic [31:0] pc_q;
   logic [31:0] instret_q, instret_d;
   logic [31:0] badaddr_q, badaddr_d;
   logic        excp_q, excp_d;

   logic        retire;
   logic        misalign;
   logic        wr_en;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic [31:0] wdata;

   always_comb begin
      valid_d = valid_q;
      fired_d = fired_q;
      load_en = 1'b0;
      if (wb.flush) begin
         valid_d = 1'b0;
         fired_d = 1'b0;
      end else if (wb.stall) begin
         fired_d = fired_q | valid_q;
      end else begin
         valid_d = wb.mem_valid;
         fired_d = 1'b0;
         load_en = 1'b1;
      end
   end

   always_comb begin
      misalign = 1'b0;
      if (sel_q == 2'b01) begin
         case (ld_type_q)
            3'b001, 3'b010: misalign = 1'b0;
            3'b011, 3'b100: misalign = alu_q[0];
            default:        misalign = |alu_q[1:0];
         endcase
      end
   end

   // Big-endian lanes: byte address 0 is the most significant byte of the word.
   always_comb begin
      ld_byte = 8'h00;
      case (alu_q[1:0])
         2'd0: ld_byte = ld_data_q[31:24];
         2'd1: ld_byte = ld_data_q[23:16];
         2'd2: ld_byte = ld_data_q[15:8];
         2'd3: ld_byte = ld_data_q[7:0];
         default: ld_byte = 8'h00;
      endcase
      ld_half = alu_q[1] ? ld_data_q[15:0] : ld_data_q[31:16];
      case (ld_type_q)
         3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  ld_ext = {24'h0, ld_byte};
         3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {16'h0, ld_half};
         default: ld_ext = ld_data_q;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'b01:   wdata = ld_ext;
         2'b10:   wdata = pc_q + LINK_OFS;
         default: wdata = alu_q;
      endcase
   end

   assign retire    = valid_q & ~fired_q;
   assign wr_en     = retire & regwr_q & ~misalign & (waddr_q != 5'd0);
   assign instret_d = instret_q + {31'd0, retire};
   assign excp_d    = retire & misalign;
   assign badaddr_d = excp_d ? alu_q : badaddr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         fired_q   <= 1'b0;
         regwr_q   <= 1'b0;
         waddr_q   <= 5'd0;
         alu_q     <= 32'd0;
         ld_data_q <= 32'd0;
         sel_q     <= 2'd0;
         ld_type_q <= 3'd0;
         pc_q      <= RESET_PC;
         instret_q <= 32'd0;
         badaddr_q <= 32'd0;
         excp_q    <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         fired_q   <= fired_d;
         instret_q <= instret_d;
         badaddr_q <= badaddr_d;
         excp_q    <= excp_d;
         if (load_en) begin
            regwr_q   <= wb.mem_regWr;
            waddr_q   <= wb.mem_writeimport;
            alu_q     <= wb.mem_alu_result;
            ld_data_q <= wb.mem_load_data;
            sel_q     <= wb.mem_wb_sel;
            ld_type_q <= wb.mem_ld_type;
            pc_q      <= wb.mem_pc;
         end
      end
   end

   assign wb.regWr       = wr_en;
   assign wb.writeimport = wr_en ? waddr_q : 5'd0;
   assign wb.Writedata   = wr_en ? wdata : 32'd0;
   assign wb.wb_excp     = excp_q;
   assign wb.wb_badaddr  = badaddr_q;
   assign wb.wb_instret  = instret_q;

endmodule
